// File: rtl/sub_stage_pkg.sv
// Shared types and constants for the sub_result_stage skid buffer.
package sub_stage_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    localparam int FLG_W      = 5;
    localparam int FLG_COUT   = 0;
    localparam int FLG_ZERO   = 1;
    localparam int FLG_NEG    = 2;
    localparam int FLG_OVF    = 3;
    localparam int FLG_SIGNED = 4;

endpackage

// File: rtl/sub_sat_counter.sv
// Saturating event counter; only compiled into builds with SUB_STAGE_STATS_EN defined.
`ifdef SUB_STAGE_STATS_EN
module sub_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // A clear that coincides with an event still counts that event.
    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = inc ? CNT_W'(1) : '0;
        else if (inc && (count_q != '1))
            count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule
`endif

// File: rtl/sub_result_stage.sv
// Registered 2-entry skid buffer behind the sub subtractor, with sticky ovf/borrow status.
// Event counters are present only when SUB_STAGE_STATS_EN is defined; otherwise they read 0.
//
// state | meaning
// EMPTY | no entry held, out_valid low
// ONE   | head entry valid, can still accept
// TWO   | head and tail valid, in_ready low
module sub_result_stage
    import sub_stage_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_cout,
    input  logic             in_zero,
    input  logic             in_neg,
    input  logic             in_ovf,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [FLG_W-1:0] out_flags,
    input  logic             clr_sticky,
    output logic             sticky_ovf,
    output logic             sticky_borrow,
    output logic [CNT_W-1:0] ovf_count,
    output logic [CNT_W-1:0] borrow_count
);

    buf_state_e       state_q;
    logic [WIDTH-1:0] head_res_q, tail_res_q;
    logic [FLG_W-1:0] head_flg_q, tail_flg_q;
    logic [FLG_W-1:0] in_flags;
    logic             sticky_ovf_q, sticky_ovf_d;
    logic             sticky_borrow_q, sticky_borrow_d;
    logic             accept, pop, ovf_ev, borrow_ev;

    always_comb begin
        in_flags             = '0;
        in_flags[FLG_COUT]   = in_cout;
        in_flags[FLG_ZERO]   = in_zero;
        in_flags[FLG_NEG]    = in_neg;
        in_flags[FLG_OVF]    = in_ovf;
        in_flags[FLG_SIGNED] = in_signed;
    end

    assign in_ready  = !rst && (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign ovf_ev    = accept && in_signed && in_ovf;
    assign borrow_ev = accept && !in_signed && !in_cout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            head_res_q <= '0;
            head_flg_q <= '0;
            tail_res_q <= '0;
            tail_flg_q <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        head_res_q <= in_result;
                        head_flg_q <= in_flags;
                        state_q    <= ONE;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        tail_res_q <= in_result;
                        tail_flg_q <= in_flags;
                        state_q    <= TWO;
                    end else if (accept && pop) begin
                        head_res_q <= in_result;
                        head_flg_q <= in_flags;
                    end else if (pop) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_res_q <= tail_res_q;
                        head_flg_q <= tail_flg_q;
                        state_q    <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    // Set has priority over clear.
    always_comb begin
        sticky_ovf_d    = ovf_ev    || (sticky_ovf_q    && !clr_sticky);
        sticky_borrow_d = borrow_ev || (sticky_borrow_q && !clr_sticky);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_ovf_q    <= 1'b0;
            sticky_borrow_q <= 1'b0;
        end else begin
            sticky_ovf_q    <= sticky_ovf_d;
            sticky_borrow_q <= sticky_borrow_d;
        end
    end

    assign out_result    = head_res_q;
    assign out_flags     = head_flg_q;
    assign sticky_ovf    = sticky_ovf_q;
    assign sticky_borrow = sticky_borrow_q;

`ifdef SUB_STAGE_STATS_EN
    sub_sat_counter #(.CNT_W(CNT_W)) u_ovf_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_sticky),
        .inc   (ovf_ev),
        .count (ovf_count)
    );

    sub_sat_counter #(.CNT_W(CNT_W)) u_borrow_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_sticky),
        .inc   (borrow_ev),
        .count (borrow_count)
    );
`else
    assign ovf_count    = '0;
    assign borrow_count = '0;
`endif

endmodule

// File: tb/tb_sub_result_stage.sv
// Directed self-checking bench for sub_result_stage (CNT_W=4 so saturation is reachable).
module tb_sub_result_stage;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
`ifdef SUB_STAGE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_result = '0;
    logic             in_cout = 1'b0, in_zero = 1'b0, in_neg = 1'b0, in_ovf = 1'b0, in_signed = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_result;
    logic [4:0]       out_flags;
    logic             clr_sticky = 1'b0;
    logic             sticky_ovf, sticky_borrow;
    logic [CNT_W-1:0] ovf_count, borrow_count;

    int n_checks = 0;
    int n_pass   = 0;

    sub_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_result     (in_result),
        .in_cout       (in_cout),
        .in_zero       (in_zero),
        .in_neg        (in_neg),
        .in_ovf        (in_ovf),
        .in_signed     (in_signed),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_flags     (out_flags),
        .clr_sticky    (clr_sticky),
        .sticky_ovf    (sticky_ovf),
        .sticky_borrow (sticky_borrow),
        .ovf_count     (ovf_count),
        .borrow_count  (borrow_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // flags vector is {signed, ovf, neg, zero, cout}
    task automatic drive(input logic [WIDTH-1:0] r, input logic [4:0] f);
        in_result = r;
        in_cout   = f[0];
        in_zero   = f[1];
        in_neg    = f[2];
        in_ovf    = f[3];
        in_signed = f[4];
        in_valid  = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
        n_checks++; if (out_result !== 8'd0) $display("FAIL reset_out_result got=%0d exp=0", out_result); else n_pass++;
        n_checks++; if (out_flags !== 5'b0) $display("FAIL reset_out_flags got=%b exp=00000", out_flags); else n_pass++;
        n_checks++; if ({sticky_ovf, sticky_borrow} !== 2'b00) $display("FAIL reset_sticky got=%b exp=00", {sticky_ovf, sticky_borrow}); else n_pass++;
        n_checks++; if (ovf_count !== 4'd0 || borrow_count !== 4'd0) $display("FAIL reset_counts got=%0d/%0d exp=0/0", ovf_count, borrow_count); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready_high got=%b exp=0", in_ready); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready_after got=%b exp=1", in_ready); else n_pass++;
    endtask

    task automatic test_unsigned_no_borrow();
        out_ready = 1'b0;
        drive(8'd2, 5'b00001);
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL nb_out_valid got=%b exp=1", out_valid); else n_pass++;
        n_checks++; if (out_result !== 8'd2) $display("FAIL nb_out_result got=%0d exp=2", out_result); else n_pass++;
        n_checks++; if (out_flags !== 5'b00001) $display("FAIL nb_out_flags got=%b exp=00001", out_flags); else n_pass++;
        n_checks++; if ({sticky_ovf, sticky_borrow} !== 2'b00) $display("FAIL nb_sticky got=%b exp=00", {sticky_ovf, sticky_borrow}); else n_pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL nb_pop_empty got=%b exp=0", out_valid); else n_pass++;
    endtask

    task automatic test_borrow();
        drive(8'd254, 5'b00100);
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_flags !== 5'b00100) $display("FAIL br_out_flags got=%b exp=00100", out_flags); else n_pass++;
        n_checks++; if (sticky_borrow !== 1'b1) $display("FAIL br_sticky_borrow got=%b exp=1", sticky_borrow); else n_pass++;
        n_checks++; if (sticky_ovf !== 1'b0) $display("FAIL br_sticky_ovf got=%b exp=0", sticky_ovf); else n_pass++;
        n_checks++; if (borrow_count !== (STATS ? 4'd1 : 4'd0)) $display("FAIL br_count got=%0d exp=%0d", borrow_count, STATS ? 1 : 0); else n_pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_ovf_and_clear();
        drive(8'd128, 5'b11100);
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_result !== 8'd128 || out_flags !== 5'b11100) $display("FAIL ov_head got=%0d/%b exp=128/11100", out_result, out_flags); else n_pass++;
        n_checks++; if (sticky_ovf !== 1'b1) $display("FAIL ov_sticky_ovf got=%b exp=1", sticky_ovf); else n_pass++;
        n_checks++; if (ovf_count !== (STATS ? 4'd1 : 4'd0)) $display("FAIL ov_count got=%0d exp=%0d", ovf_count, STATS ? 1 : 0); else n_pass++;
        // clear coinciding with another ovf accept, plus accept-with-pop in ONE
        clr_sticky = 1'b1;
        out_ready  = 1'b1;
        drive(8'd129, 5'b11100);
        tick();
        clr_sticky = 1'b0;
        out_ready  = 1'b0;
        in_valid   = 1'b0;
        n_checks++; if (sticky_ovf !== 1'b1) $display("FAIL clr_set_wins got=%b exp=1", sticky_ovf); else n_pass++;
        n_checks++; if (ovf_count !== (STATS ? 4'd1 : 4'd0)) $display("FAIL clr_ovf_count got=%0d exp=%0d", ovf_count, STATS ? 1 : 0); else n_pass++;
        n_checks++; if (sticky_borrow !== 1'b0 || borrow_count !== 4'd0) $display("FAIL clr_borrow got=%b/%0d exp=0/0", sticky_borrow, borrow_count); else n_pass++;
        n_checks++; if (out_valid !== 1'b1 || out_result !== 8'd129) $display("FAIL acc_pop_head got=%b/%0d exp=1/129", out_valid, out_result); else n_pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL ov_drain got=%b exp=0", out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(8'd10, 5'b00001);
        tick();
        drive(8'd20, 5'b00001);
        tick();
        drive(8'd30, 5'b00001);
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready got=%b exp=0", in_ready); else n_pass++;
        tick();
        n_checks++; if (out_result !== 8'd10 || in_ready !== 1'b0) $display("FAIL bp_hold got=%0d/%b exp=10/0", out_result, in_ready); else n_pass++;
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_result !== 8'd20 || in_ready !== 1'b1) $display("FAIL bp_second got=%0d/%b exp=20/1", out_result, in_ready); else n_pass++;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_result !== 8'd30) $display("FAIL bp_third got=%b/%0d exp=1/30", out_valid, out_result); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_no_dup got=%b exp=0", out_valid); else n_pass++;
        out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            drive(8'(i), 5'b00000);
            tick();
            if (i == 3) begin
                n_checks++; if (borrow_count !== (STATS ? 4'd3 : 4'd0)) $display("FAIL sat_mid got=%0d exp=%0d", borrow_count, STATS ? 3 : 0); else n_pass++;
            end
        end
        in_valid = 1'b0;
        n_checks++; if (borrow_count !== (STATS ? 4'd15 : 4'd0)) $display("FAIL sat_final got=%0d exp=%0d", borrow_count, STATS ? 15 : 0); else n_pass++;
        n_checks++; if (out_result !== 8'd17) $display("FAIL sat_last_head got=%0d exp=17", out_result); else n_pass++;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_in_two();
        out_ready = 1'b0;
        drive(8'd1, 5'b11000);
        tick();
        drive(8'd2, 5'b00000);
        tick();
        n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL rt_in_two got=%b/%b exp=0/1", in_ready, out_valid); else n_pass++;
        drive(8'd3, 5'b11000);
        out_ready = 1'b1;
        rst = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0 || out_result !== 8'd0 || out_flags !== 5'b0) $display("FAIL rt_outputs got=%b/%0d/%b exp=0/0/00000", out_valid, out_result, out_flags); else n_pass++;
        n_checks++; if ({sticky_ovf, sticky_borrow} !== 2'b00 || ovf_count !== 4'd0 || borrow_count !== 4'd0) $display("FAIL rt_status got=%b/%0d/%0d exp=00/0/0", {sticky_ovf, sticky_borrow}, ovf_count, borrow_count); else n_pass++;
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rt_ready_after got=%b exp=1", in_ready); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rt_ignored_handshake got=%b exp=0", out_valid); else n_pass++;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        test_reset();
        test_unsigned_no_borrow();
        test_borrow();
        test_ovf_and_clear();
        test_back_to_back();
        test_saturation();
        test_reset_in_two();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sub_result_stage.md
# sub_result_stage

Registered result stage directly downstream of the `sub` subtractor. It captures `final_out` and the four flags under a valid/ready handshake and buffers them in a 2-entry skid buffer, so the subtractor's combinational path is cut from the consumer. It also maintains sticky overflow and borrow status, plus optional saturating event counters for software and debug readout.

## Interface
- `WIDTH`, default 8: result width; must match the `sub` instance.
- `CNT_W`, default 16: width of the event counters.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  the `sub` outputs hold a result to capture.
- `in_ready`  out  1  the stage can accept a result this cycle.
- `in_result`  in  WIDTH  from `final_out`.
- `in_cout`, `in_zero`, `in_neg`, `in_ovf`  in  1 each  from the `sub` flags.
- `in_signed`  in  1  the `signed_en` value used for this result.
- `out_valid`  out  1  the head entry is valid.
- `out_ready`  in  1  the consumer accepts the head entry.
- `out_result`  out  WIDTH  head result.
- `out_flags`  out  5  head flags, {signed, ovf, neg, zero, cout}.
- `clr_sticky`  in  1  clears both sticky bits.
- `sticky_ovf`  out  1  set when a signed result with overflow is accepted.
- `sticky_borrow`  out  1  set when an unsigned result with `cout`=0 is accepted.
- `ovf_count`, `borrow_count`  out  CNT_W each  saturating event counts.

## Operation
- Accept occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- Buffer states:
  - EMPTY: accept -> ONE.
  - ONE: accept without pop -> TWO; pop without accept -> EMPTY; accept with pop -> ONE, and the new entry becomes the head.
  - TWO: pop -> ONE, and the second entry moves to the head; no accept is possible in this state.
- `in_ready` = !rst && state != TWO. `out_valid` = state != EMPTY.
- Entries are stored unmodified, with no arithmetic on the data. Order is strictly FIFO.
- Event qualification, on accept only:
  - ovf event = `in_signed && in_ovf`.
  - borrow event = `!in_signed && !in_cout`.
- Sticky bits: an event sets the bit; `clr_sticky` clears it. If an event and `clr_sticky` occur in the same cycle, set wins.
- Counters increment by 1 per qualifying accept and saturate at all-ones with no wrap. `clr_sticky` also zeroes both counters; if it coincides with an event, the counter loads 1.

## Timing
- Latency is 1 cycle: an accept at edge N gives `out_valid`=1 with that data after edge N.
- There is no combinational path from `in_valid` or data to any output. `in_ready` depends only on the state register and `rst`.
- Reset, synchronous:
  - state returns to EMPTY.
  - `out_valid`=0, `out_result`=0, `out_flags`=0.
  - `sticky_ovf`=0, `sticky_borrow`=0.
  - `ovf_count`=0, `borrow_count`=0.
  - `in_ready`=0 while `rst` is high and 1 on the first cycle after.
- Reset mid-operation discards buffered entries without a pop. Any handshake in the reset cycle is ignored.
- Sticky bits and counters reflect an accept on the cycle after the accepting edge.

## Configuration
- `SUB_STAGE_STATS_EN` defined: both counters are implemented as described above.
- `SUB_STAGE_STATS_EN` undefined: the counter logic is removed and `ovf_count`/`borrow_count` are tied to 0. Sticky bits and the buffer are unaffected.

## Structure
- Package `sub_stage_pkg` holds:
  - the buffer state enum (EMPTY, ONE, TWO);
  - the `out_flags` bit-index constants (FLG_COUT=0, FLG_ZERO=1, FLG_NEG=2, FLG_OVF=3, FLG_SIGNED=4).
- Sub-module `sub_sat_counter` (CNT_W; ports `clk`, `rst`, `clr`, `inc`, `count`) is instantiated twice, and only under `SUB_STAGE_STATS_EN`.

## Test plan
- Unsigned 5-3: `in_result`=2, cout=1 -> one cycle later `out_result`=2, `out_flags`=5'b00001, no sticky bits set.
- Unsigned 3-5: `in_result`=254, cout=0, neg=1 -> `sticky_borrow`=1, `borrow_count`=1, `sticky_ovf`=0.
- Signed 127-(-1): `in_result`=128, ovf=1, `in_signed`=1 -> `sticky_ovf`=1, `ovf_count`=1. Then `clr_sticky` together with another ovf accept -> `sticky_ovf` stays 1 and `ovf_count`=1.
- Backpressure: `out_ready`=0 and offer 10, 20, 30 on consecutive cycles -> 10 and 20 are accepted, then `in_ready`=0 and 30 is held. Raise `out_ready` -> outputs 10, 20, 30 in order with no loss or duplication.
- Saturation (CNT_W=4, macro defined): 17 borrow events -> `borrow_count`=15. With the macro undefined, the counters read 0 throughout.
- Assert `rst` while in state TWO -> next cycle `out_valid`=0, all status outputs 0, and `in_ready`=1 after `rst` deasserts.
